// File: rtl/clk_div_ctrl_pkg.sv
// Shared definitions for the UART clock-divider sequencing controller:
// FSM state encoding, the minimum ratio that keeps the divider enabled,
// and the drain-counter width.
package clk_div_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GATE  = 3'd1,
        S_DRAIN = 3'd2,
        S_LOAD  = 3'd3,
        S_ACK   = 3'd4
    } state_e;

    // Plain-vector copies of the state codes for the state register.
    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_GATE  = S_GATE;
    localparam logic [2:0] ST_DRAIN = S_DRAIN;
    localparam logic [2:0] ST_LOAD  = S_LOAD;
    localparam logic [2:0] ST_ACK   = S_ACK;

    // Ratios below this value put the divider in bypass (enable held low).
    localparam int MIN_EN_RATIO = 2;

    // Width of the drain counter; holds SETTLE_CYCLES-1 for 1..15.
    localparam int CNT_W = 4;

    // True when a ratio is large enough for the divider to run.
    function automatic logic ratio_enables(input logic [31:0] ratio);
        return (ratio >= 32'(MIN_EN_RATIO));
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Request/ack and divider-control signals of clk_div_ctrl.
// The slave modport is the controller; the master modport is the
// requester/divider side.
interface clk_div_ctrl_if #(
    parameter int WIDTH = 6
) ();
    logic             i_enable;
    logic             i_req0;
    logic [WIDTH-1:0] i_ratio0;
    logic             o_ack0;
    logic             i_req1;
    logic [WIDTH-1:0] i_ratio1;
    logic             o_ack1;
    logic [WIDTH-1:0] o_div_ratio;
    logic             o_clk_en;
    logic             o_busy;

    modport slave (
        input  i_enable, i_req0, i_ratio0, i_req1, i_ratio1,
        output o_ack0, o_ack1, o_div_ratio, o_clk_en, o_busy
    );

    modport master (
        output i_enable, i_req0, i_ratio0, i_req1, i_ratio1,
        input  o_ack0, o_ack1, o_div_ratio, o_clk_en, o_busy
    );
endinterface

// File: rtl/clk_div_ctrl_arb.sv
// Two-requester arbiter for clk_div_ctrl.
// Macro CLK_DIV_CTRL_RR_EN: defined -> round-robin with a 1-bit pointer
// favouring the requester not granted last; undefined -> fixed priority
// (requester 0 first), purely combinational.
module clk_div_ctrl_arb (
`ifdef CLK_DIV_CTRL_RR_EN
    input  logic i_ref_clk,
    input  logic i_rst_n,
    input  logic i_take,
`endif
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt_valid,
    output logic o_gnt_idx
);

`ifdef CLK_DIV_CTRL_RR_EN
    logic rr_ptr_r;

    // Pick the favoured requester on contention, otherwise whoever asks.
    always_comb begin
        o_gnt_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_gnt_idx = rr_ptr_r;
        end else begin
            o_gnt_idx = i_req1 & ~i_req0;
        end
    end

    // Hand priority to the other requester after every accepted grant.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_r <= 1'b0;
        end else if (i_take && o_gnt_valid) begin
            rr_ptr_r <= ~o_gnt_idx;
        end
    end
`else
    // Requester 0 always wins when both ask.
    always_comb begin
        o_gnt_valid = i_req0 | i_req1;
        if (i_req0) begin
            o_gnt_idx = 1'b0;
        end else begin
            o_gnt_idx = i_req1;
        end
    end
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Sequencing controller for the UART integer clock divider. Grants one
// ratio change at a time, gates the divider enable for the settle window
// around each change, then acks the requester.
// Macro CLK_DIV_CTRL_RR_EN selects round-robin arbitration (see arbiter).
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int               WIDTH         = 6,
    parameter logic [WIDTH-1:0] DEFAULT_RATIO = 6'd32,
    parameter int               SETTLE_CYCLES = 4
) (
    input  logic          i_ref_clk,
    input  logic          i_rst_n,
    clk_div_ctrl_if.slave bus
);

    // GATE itself is the first disabled cycle, so DRAIN lasts one cycle less.
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] pend_ratio_r;
    logic [WIDTH-1:0] div_ratio_r;
    logic [WIDTH-1:0] gnt_ratio_s;
    logic             gnt_idx_r;
    logic             gnt_valid_s;
    logic             gnt_idx_s;
    logic             sel_idx_s;
    logic             clk_en_next_s;
    logic             clk_en_r;
    logic             ack0_r;
    logic             ack1_r;
    logic             busy_r;

    clk_div_ctrl_arb u_arb (
`ifdef CLK_DIV_CTRL_RR_EN
        .i_ref_clk   (i_ref_clk),
        .i_rst_n     (i_rst_n),
        .i_take      (state_r == ST_IDLE),
`endif
        .i_req0      (bus.i_req0),
        .i_req1      (bus.i_req1),
        .o_gnt_valid (gnt_valid_s),
        .o_gnt_idx   (gnt_idx_s)
    );

    // Ratio of the arbiter's current pick and the requester owning the sequence.
    always_comb begin
        if (gnt_idx_s) begin
            gnt_ratio_s = bus.i_ratio1;
        end else begin
            gnt_ratio_s = bus.i_ratio0;
        end
        if (state_r == ST_IDLE) begin
            sel_idx_s = gnt_idx_s;
        end else begin
            sel_idx_s = gnt_idx_r;
        end
    end

    // Next-state logic; an unchanged ratio skips straight to the ack.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!gnt_valid_s) begin
                    next_state_s = ST_IDLE;
                end else if (gnt_ratio_s == div_ratio_r) begin
                    next_state_s = ST_ACK;
                end else begin
                    next_state_s = ST_GATE;
                end
            end
            ST_GATE: begin
                if (DRAIN_LOAD == {CNT_W{1'b0}}) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_r <= CNT_W'(1)) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_LOAD: next_state_s = ST_ACK;
            ST_ACK:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Enable only while resting (IDLE/ACK now and next), so a pending change
    // drops it at once and it returns only after the ack cycle.
    always_comb begin
        if (bus.i_enable && ratio_enables(32'(div_ratio_r)) &&
            ((state_r == ST_IDLE) || (state_r == ST_ACK)) &&
            ((next_state_s == ST_IDLE) || (next_state_s == ST_ACK))) begin
            clk_en_next_s = 1'b1;
        end else begin
            clk_en_next_s = 1'b0;
        end
    end

    // FSM state, drain counter and captured grant.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            pend_ratio_r <= DEFAULT_RATIO;
            gnt_idx_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_valid_s) begin
                        pend_ratio_r <= gnt_ratio_s;
                        gnt_idx_r    <= gnt_idx_s;
                    end
                end
                ST_GATE:  cnt_r <= DRAIN_LOAD;
                ST_DRAIN: cnt_r <= cnt_r - CNT_W'(1);
                default:  cnt_r <= cnt_r;
            endcase
        end
    end

    // Registered divider controls, ack pulses and busy flag.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_ratio_r <= DEFAULT_RATIO;
            clk_en_r    <= 1'b0;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (state_r == ST_LOAD) begin
                div_ratio_r <= pend_ratio_r;
            end
            clk_en_r <= clk_en_next_s;
            ack0_r   <= (next_state_s == ST_ACK) && !sel_idx_s;
            ack1_r   <= (next_state_s == ST_ACK) &&  sel_idx_s;
            busy_r   <= (next_state_s != ST_IDLE);
        end
    end

    assign bus.o_div_ratio = div_ratio_r;
    assign bus.o_clk_en    = clk_en_r;
    assign bus.o_ack0      = ack0_r;
    assign bus.o_ack1      = ack1_r;
    assign bus.o_busy      = busy_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus a random
// loop, with expectations computed from the cycle timeline of a ratio change.
module tb_clk_div_ctrl;

    localparam int         W   = 6;
    localparam int         S   = 4;
    localparam logic [5:0] DEF = 6'd32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clk_div_ctrl_if #(.WIDTH(W)) bus ();

    clk_div_ctrl #(
        .WIDTH         (W),
        .DEFAULT_RATIO (DEF),
        .SETTLE_CYCLES (S)
    ) dut (
        .i_ref_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_ratio = 32;   // ratio the divider should currently hold
    int favour    = 0;    // requester favoured on contention (round-robin)
    int en        = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e_en, input int e_ratio,
                              input int e_a0, input int e_a1, input int e_busy);
        chk({tag, " clk_en"}, 32'(bus.o_clk_en), 32'(e_en));
        chk({tag, " ratio"},  32'(bus.o_div_ratio), 32'(e_ratio));
        chk({tag, " ack0"},   32'(bus.o_ack0), 32'(e_a0));
        chk({tag, " ack1"},   32'(bus.o_ack1), 32'(e_a1));
        chk({tag, " busy"},   32'(bus.o_busy), 32'(e_busy));
    endtask

    // Entered at the negedge of cycle t0 with request idx already high.
    // Walks t0+1 .. ack cycle, drops the request on its ack, then checks
    // the following IDLE cycle.
    task automatic run_seq(input string tag, input int idx, input int nr);
        int  old;
        bit  chg;
        int  k_ack;
        int  e_en;
        int  e_ratio;
        int  ack;
        old   = cur_ratio;
        chg   = (nr != old);
        k_ack = chg ? S + 2 : 1;
        for (int k = 1; k <= k_ack; k++) begin
            @(posedge clk);
            @(negedge clk);
            e_en    = chg ? 0 : ((en != 0 && old >= 2) ? 1 : 0);
            e_ratio = (chg && k >= S + 2) ? nr : old;
            ack     = (k == k_ack) ? 1 : 0;
            check_outs($sformatf("%s t0+%0d", tag, k), e_en, e_ratio,
                       (idx == 0) ? ack : 0, (idx == 1) ? ack : 0, 1);
            if (k == k_ack) begin
                if (idx == 0) bus.i_req0 = 1'b0;
                else          bus.i_req1 = 1'b0;
            end
        end
        cur_ratio = nr;
        favour    = 1 - idx;
        @(posedge clk);
        @(negedge clk);
        check_outs($sformatf("%s idle", tag), (en != 0 && nr >= 2) ? 1 : 0, nr, 0, 0, 0);
    endtask

    task automatic request(input string tag, input int idx, input int nr);
        if (idx == 0) begin
            bus.i_ratio0 = 6'(nr);
            bus.i_req0   = 1'b1;
        end else begin
            bus.i_ratio1 = 6'(nr);
            bus.i_req1   = 1'b1;
        end
        run_seq(tag, idx, nr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int idx;
        int nr;
        bus.i_enable = 1'b1;
        bus.i_req0   = 1'b0;
        bus.i_req1   = 1'b0;
        bus.i_ratio0 = 6'd0;
        bus.i_ratio1 = 6'd0;

        // Reset values, then enable one edge after release.
        repeat (3) @(negedge clk);
        check_outs("reset", 0, 32, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("release clk_en", 32'(bus.o_clk_en), 32'd0);
        @(negedge clk);
        check_outs("post-release", 1, 32, 0, 0, 0);

        // Ratio change, same-ratio request, bypass ratio, recovery.
        request("r0 ratio8", 0, 8);
        request("r1 same", 1, 8);
        request("r1 ratio1", 1, 1);
        request("r0 ratio5", 0, 5);

        // Simultaneous requests.
        bus.i_ratio0 = 6'd10;
        bus.i_ratio1 = 6'd12;
        bus.i_req0   = 1'b1;
        bus.i_req1   = 1'b1;
`ifdef CLK_DIV_CTRL_RR_EN
        w = favour;
`else
        w = 0;
`endif
        run_seq("both first", w, (w == 0) ? 10 : 12);
        run_seq("both second", 1 - w, (w == 0) ? 12 : 10);

        // Enable drop and restore while idle.
        en = 0;
        bus.i_enable = 1'b0;
        @(negedge clk);
        check_outs("enable low", 0, cur_ratio, 0, 0, 0);
        en = 1;
        bus.i_enable = 1'b1;
        @(negedge clk);
        check_outs("enable high", (cur_ratio >= 2) ? 1 : 0, cur_ratio, 0, 0, 0);

        // Reset during DRAIN: no ack, defaults back, request completes after.
        bus.i_ratio0 = 6'd40;
        bus.i_req0   = 1'b1;
        repeat (3) @(negedge clk);
        chk("drain busy", 32'(bus.o_busy), 32'd1);
        chk("drain clk_en", 32'(bus.o_clk_en), 32'd0);
        rst_n = 1'b0;
        #1;
        check_outs("mid reset", 0, 32, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_outs("held reset", 0, 32, 0, 0, 0);
        cur_ratio = 32;
        favour    = 0;
        rst_n     = 1'b1;
        run_seq("after reset", 0, 40);

        // Random requests, ratios and enable levels.
        for (int i = 0; i < 10; i++) begin
            idx = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) nr = cur_ratio;
            else                           nr = int'($urandom_range(0, 63));
            en = ($urandom_range(0, 4) != 0) ? 1 : 0;
            bus.i_enable = en[0];
            request($sformatf("rand%0d", i), idx, nr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
